// File: rtl/display_pkg.sv
// Shared types for the ADC display formatter: display modes, FSM states and digit count.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'b00,
    MODE_AVG  = 2'b01,
    MODE_VOLT = 2'b10,
    MODE_HOLD = 2'b11
  } disp_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    PUBLISH
  } fsm_state_t;

  localparam int DIGITS = 4;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock, IN_W steps per conversion.
module bin2bcd_seq #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out
);

  localparam int ITER_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [DIGITS*4-1:0] bcd_q, bcd_d, bcd_adj;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                active_q, active_d;
  logic                last_iter;

  // done marks the final step, so bcd_q holds the result from the following cycle on
  assign last_iter = (iter_q == ITER_W'(IN_W - 1));
  assign done      = active_q && last_iter;
  assign bcd_out   = bcd_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    bcd_d    = bcd_q;
    bin_d    = bin_q;
    iter_d   = iter_q;
    active_d = active_q;
    if (start) begin
      bcd_d    = '0;
      bin_d    = bin_in;
      iter_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d  = {bcd_adj[DIGITS*4-2:0], bin_q[IN_W-1]};
      bin_d  = {bin_q[IN_W-2:0], 1'b0};
      iter_d = iter_q + ITER_W'(1);
      if (last_iter) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      iter_q   <= '0;
    end else begin
      active_q <= active_d;
      iter_q   <= iter_d;
    end
  end

  always_ff @(posedge clk) begin
    bcd_q <= bcd_d;
    bin_q <= bin_d;
  end

endmodule

// File: rtl/adc_display_formatter.sv
// Periodically snapshots one ADC word and formats it as four 7-segment nibbles
// (hex for raw/averaged data, X.XXX decimal for millivolts) with dp and blanking masks.
module adc_display_formatter
  import display_pkg::*;
#(
  parameter int UPDATE_TICKS = 25_000_000,
  parameter int IN_W         = 16,
  parameter int DEC_MAX      = 9999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       raw_adc_data,
  input  logic [IN_W-1:0]       averaged_adc_data,
  input  logic [IN_W-1:0]       scaled_voltage_data,
  input  logic [1:0]            mode_sel,
  output logic [DIGITS*4-1:0]   display_word,
  output logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  busy,
  output logic                  update_pulse
);

  localparam int CNT_W = (UPDATE_TICKS > 1) ? $clog2(UPDATE_TICKS) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [DIGITS-1:0] DP_VOLT   = {1'b1, {(DIGITS-1){1'b0}}};

  function automatic logic [IN_W-1:0] sat_dec(input logic [IN_W-1:0] v);
    return (v > IN_W'(DEC_MAX)) ? IN_W'(DEC_MAX) : v;
  endfunction

  // Leading zero nibbles go dark; digit0 always stays lit so zero shows as "0"
  function automatic logic [DIGITS-1:0] lead_blank(input logic [DIGITS*4-1:0] w);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run  = run && (w[i*4 +: 4] == 4'd0);
      m[i] = run;
    end
    return m;
  endfunction

  fsm_state_t          state_q, state_d;
  disp_mode_t          mode_q, mode_d, mode_in;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]     snap_q, snap_d;
  logic [DIGITS*4-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                pulse_q, pulse_d;
  logic                tick;
  logic                conv_start;
  logic                conv_done;
  logic [DIGITS*4-1:0] conv_bcd;

  assign mode_in      = disp_mode_t'(mode_sel);
  assign tick         = (cnt_q == CNT_W'(UPDATE_TICKS - 1));
  assign cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
  assign busy         = (state_q != IDLE);
  assign display_word = disp_q;
  assign dp_mask      = dp_q;
  assign blank_mask   = blank_q;
  assign update_pulse = pulse_q;

  bin2bcd_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (sat_dec(scaled_voltage_data)),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    snap_d     = snap_q;
    disp_d     = disp_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    pulse_d    = 1'b0;
    conv_start = 1'b0;

    case (state_q)
      IDLE: begin
        // Ticks arriving while busy are simply dropped, never queued
        if (tick) begin
          case (mode_in)
            MODE_RAW: begin
              mode_d  = MODE_RAW;
              snap_d  = raw_adc_data;
              state_d = PUBLISH;
            end
            MODE_AVG: begin
              mode_d  = MODE_AVG;
              snap_d  = averaged_adc_data;
              state_d = PUBLISH;
            end
            MODE_VOLT: begin
              mode_d     = MODE_VOLT;
              conv_start = 1'b1;
              state_d    = CONVERT;
            end
            default: ;
          endcase
        end
      end

      CONVERT: begin
        if (conv_done) begin
          state_d = PUBLISH;
        end
      end

      PUBLISH: begin
        state_d = IDLE;
        pulse_d = 1'b1;
        if (mode_q == MODE_VOLT) begin
          disp_d  = conv_bcd;
          dp_d    = DP_VOLT;
          blank_d = '0;
        end else begin
          disp_d  = (DIGITS*4)'(snap_q);
          dp_d    = '0;
          blank_d = lead_blank((DIGITS*4)'(snap_q));
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_RAW;
      cnt_q   <= '0;
      disp_q  <= '0;
      dp_q    <= '0;
      blank_q <= BLANK_RST;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

endmodule

// File: tb/tb_adc_display_formatter.sv
// Randomized scoreboard bench: a timing/arithmetic reference model queues expected refreshes,
// a negedge monitor checks each update_pulse plus busy and output hold every cycle.
module tb_adc_display_formatter;

  localparam int TICKS   = 8;
  localparam int HEX_LAT = 2;
  localparam int DEC_LAT = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] raw_adc_data = '0;
  logic [15:0] averaged_adc_data = '0;
  logic [15:0] scaled_voltage_data = '0;
  logic [1:0]  mode_sel = 2'b00;
  logic [15:0] display_word;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        busy;
  logic        update_pulse;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  dp;
    logic [3:0]  bl;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int cyc = 0;
  int rc = 0;
  int free_at = 0;
  int accept_at = -1;
  int accepts = 0;
  bit was_reset = 1'b0;

  logic [15:0] held_w  = '0;
  logic [3:0]  held_dp = '0;
  logic [3:0]  held_bl = 4'b1110;

  adc_display_formatter #(
    .UPDATE_TICKS (TICKS),
    .IN_W         (16),
    .DEC_MAX      (9999)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .raw_adc_data        (raw_adc_data),
    .averaged_adc_data   (averaged_adc_data),
    .scaled_voltage_data (scaled_voltage_data),
    .mode_sel            (mode_sel),
    .display_word        (display_word),
    .dp_mask             (dp_mask),
    .blank_mask          (blank_mask),
    .busy                (busy),
    .update_pulse        (update_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t hex_exp(input logic [15:0] v, input int due);
    exp_t e;
    e.w   = v;
    e.dp  = 4'b0000;
    e.bl  = {v < 16'h1000, v < 16'h0100, v < 16'h0010, 1'b0};
    e.due = due;
    return e;
  endfunction

  function automatic exp_t dec_exp(input logic [15:0] v, input int due);
    exp_t e;
    int   s;
    s     = (int'(v) > 9999) ? 9999 : int'(v);
    e.w   = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    e.dp  = 4'b1000;
    e.bl  = 4'b0000;
    e.due = due;
    return e;
  endfunction

  // Reference model: a refresh every TICKS cycles, accepted only when the previous update has finished
  always @(posedge clk) begin
    was_reset = reset;
    if (reset) begin
      sb.delete();
      free_at   = 0;
      accept_at = -1;
      rc        = 0;
    end else begin
      if (rc == TICKS - 1 && cyc >= free_at && mode_sel != 2'b11) begin
        if (mode_sel == 2'b10) begin
          sb.push_back(dec_exp(scaled_voltage_data, cyc + DEC_LAT));
          free_at = cyc + DEC_LAT;
        end else begin
          sb.push_back(hex_exp((mode_sel == 2'b00) ? raw_adc_data : averaged_adc_data,
                               cyc + HEX_LAT));
          free_at = cyc + HEX_LAT;
        end
        accept_at = cyc;
        accepts++;
      end
      rc = (rc == TICKS - 1) ? 0 : rc + 1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (was_reset) begin
      held_w  = '0;
      held_dp = '0;
      held_bl = 4'b1110;
      chk("reset_pulse", 32'(update_pulse), 32'd0);
    end else if (update_pulse) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", 32'(update_pulse), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(mon_e.due));
        chk("display_word", 32'(display_word), 32'(mon_e.w));
        chk("dp_mask", 32'(dp_mask), 32'(mon_e.dp));
        chk("blank_mask", 32'(blank_mask), 32'(mon_e.bl));
        held_w  = mon_e.w;
        held_dp = mon_e.dp;
        held_bl = mon_e.bl;
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("missing_pulse", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
    chk("busy", 32'(busy), 32'(cyc > accept_at && cyc < free_at));
    chk("held_word", 32'(display_word), 32'(held_w));
    chk("held_dp", 32'(dp_mask), 32'(held_dp));
    chk("held_blank", 32'(blank_mask), 32'(held_bl));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int mode, input int v);
    mode_sel            = 2'(mode);
    raw_adc_data        = 16'($urandom_range(0, 4095));
    averaged_adc_data   = 16'($urandom) & 16'hFFF0;
    scaled_voltage_data = 16'($urandom_range(0, 12000));
    case (mode)
      0:       raw_adc_data        = 16'(v);
      1:       averaged_adc_data   = 16'(v);
      2:       scaled_voltage_data = 16'(v);
      default: ;
    endcase
  endtask

  task automatic wait_accept();
    int a0 = accepts;
    for (int i = 0; i < 40 && accepts == a0; i++) step(1);
    if (accepts == a0) begin
      fails++;
      $display("FAIL accept_timeout: no refresh accepted within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  function automatic int rand_mag(input int mask);
    return int'(16'($urandom >> $urandom_range(16, 31))) & mask;
  endfunction

  int dm[10] = '{2, 2, 2, 2, 2, 2, 0, 1, 0, 0};
  int dv[10] = '{3300, 1234, 0, 12000, 9999, 10000, 'h0ABC, 0, 0, 'h0FFF};

  initial begin
    reset = 1'b1;
    step(3);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_in(dm[i], dv[i]);
      step(32);
    end

    // Hold mode must freeze everything while inputs churn
    set_in(0, 'h1234);
    step(16);
    for (int i = 0; i < 5 * TICKS; i++) begin
      set_in(3, 0);
      step(1);
    end

    // Mode change mid-conversion: the decimal result still publishes first
    set_in(2, 5678);
    wait_accept();
    step(5);
    set_in(1, 'h00F0);
    step(40);

    // Reset mid-conversion, then a clean conversion afterwards
    set_in(3, 0);
    step(24);
    set_in(2, 4321);
    wait_accept();
    step(6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_in(2, 2718);
    step(40);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    set_in(0, rand_mag('h0FFF));
        2, 3:    set_in(1, rand_mag('hFFF0));
        4, 5, 6: set_in(2, ($urandom_range(0, 3) == 0) ? rand_mag('hFFFF)
                                                        : int'($urandom_range(0, 12000)));
        default: set_in(3, 0);
      endcase
      step($urandom_range(1, 25));
    end

    set_in(3, 0);
    step(30);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
